// File: rtl/hdmi_out_pkg.sv
// Shared types and constants for the HDMI output line fetch path.
// Holds the reader FSM encoding, bus field widths and the line-size helper.
package hdmi_out_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_BEAT     = DEFAULT_DATA_WIDTH / 8;
  localparam int LEN_W              = 12;
  localparam int ADDR_W             = 32;
  localparam int REM_W              = 20;
  localparam int BEAT_CNT_W         = 7;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    REQ,
    XFER
  } state_t;

  // Whole beats in one line; a trailing partial beat is dropped.
  function automatic logic [REM_W-1:0] calc_line_beats(
    input logic [31:0] stride,
    input logic [31:0] bpp,
    input int          shift
  );
    logic [63:0] line_bytes;
    line_bytes = {32'b0, stride} * {32'b0, bpp};
    return REM_W'(line_bytes >> shift);
  endfunction

endpackage

// File: rtl/line_burst_reader_burst_planner.sv
// Sizes the next burst of a line and precomputes the address and
// remaining-beat values that apply once that burst has completed.
module burst_planner
  import hdmi_out_pkg::*;
#(
  parameter int BURST_BEATS = 16,
  parameter int BEAT_BYTES  = BYTES_PER_BEAT
) (
  input  logic [ADDR_W-1:0]     cur_addr,
  input  logic [REM_W-1:0]      remaining,
  output logic [BEAT_CNT_W-1:0] burst_beats,
  output logic [LEN_W-1:0]      burst_len,
  output logic [ADDR_W-1:0]     next_addr,
  output logic [REM_W-1:0]      next_remaining
);

  always_comb begin
    if (remaining < REM_W'(BURST_BEATS)) begin
      burst_beats = BEAT_CNT_W'(remaining);
    end else begin
      burst_beats = BEAT_CNT_W'(BURST_BEATS);
    end
    burst_len      = LEN_W'(burst_beats) * LEN_W'(BEAT_BYTES);
    // Wraps modulo 2^32; software keeps lines clear of 4 KB crossings.
    next_addr      = cur_addr + ADDR_W'(burst_len);
    next_remaining = remaining - REM_W'(burst_beats);
  end

endmodule

// File: rtl/line_burst_reader.sv
// Fetches one display line from DDR per go_fill_fifo as fixed-size master
// burst reads, passing each beat straight into the HDMI pixel FIFO.
module line_burst_reader
  import hdmi_out_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int BURST_BEATS = 16,
  parameter int FIFO_DEPTH  = 256
) (
  input  logic                          Bus2IP_Clk,
  input  logic                          Bus2IP_Reset,
  input  logic                          go_fill_fifo,
  input  logic [31:0]                   ddr_addr_to_read,
  input  logic [31:0]                   LINE_STRIDE,
  input  logic [31:0]                   NUM_BYTES_PER_PIXEL,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_vacancy,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          mst_rd_req,
  output logic [31:0]                   mst_addr,
  output logic [11:0]                   mst_length,
  input  logic                          mst_cmdack,
  input  logic                          mst_cmplt,
  input  logic                          mst_error,
  input  logic [DATA_WIDTH-1:0]         mst_rd_data,
  input  logic                          mst_rd_src_rdy,
  output logic                          mst_rd_dst_rdy,
  output logic                          busy,
  output logic                          line_done,
  output logic                          overrun,
  output logic                          rd_err
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_W-1:0]      cur_addr;
  logic [REM_W-1:0]       remaining;
  logic [BEAT_CNT_W-1:0]  beat_cnt;
  logic [BEAT_CNT_W-1:0]  beat_cnt_nxt;
  logic                   cmplt_seen;
  logic                   line_done_r;
  logic                   overrun_r;
  logic                   rd_err_r;

  logic [REM_W-1:0]       line_beats;
  logic [BEAT_CNT_W-1:0]  burst_beats;
  logic [LEN_W-1:0]       burst_len;
  logic [ADDR_W-1:0]      next_addr;
  logic [REM_W-1:0]       next_remaining;

  logic                   xfer_room;
  logic                   load_line;
  logic                   zero_line;
  logic                   advance;
  logic                   finish_line;
  logic                   xfer_err;
  logic                   go_rejected;
  logic                   stay_xfer;

  assign line_beats = calc_line_beats(LINE_STRIDE, NUM_BYTES_PER_PIXEL, BEAT_SHIFT);

  burst_planner #(
    .BURST_BEATS (BURST_BEATS),
    .BEAT_BYTES  (BEAT_BYTES)
  ) u_planner (
    .cur_addr       (cur_addr),
    .remaining      (remaining),
    .burst_beats    (burst_beats),
    .burst_len      (burst_len),
    .next_addr      (next_addr),
    .next_remaining (next_remaining)
  );

  // Beats beyond the planned burst are refused, never pushed.
  always_comb begin
    xfer_room    = (state == XFER) && (beat_cnt < burst_beats);
    fifo_wr_en   = xfer_room && mst_rd_src_rdy;
    fifo_wr_data = fifo_wr_en ? mst_rd_data : '0;
    beat_cnt_nxt = beat_cnt + BEAT_CNT_W'(fifo_wr_en);
  end

  always_comb begin
    state_nxt   = state;
    load_line   = 1'b0;
    zero_line   = 1'b0;
    advance     = 1'b0;
    finish_line = 1'b0;
    xfer_err    = 1'b0;
    case (state)
      IDLE: begin
        // The line_done cycle still counts as busy for a new request.
        if (go_fill_fifo && !line_done_r) begin
          if (line_beats == '0) begin
            zero_line = 1'b1;
          end else begin
            load_line = 1'b1;
            state_nxt = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (32'(fifo_vacancy) >= 32'(burst_beats)) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mst_cmdack) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (mst_cmplt && mst_error) begin
          xfer_err  = 1'b1;
          state_nxt = IDLE;
        end else if ((beat_cnt_nxt == burst_beats) && (cmplt_seen || mst_cmplt)) begin
          advance = 1'b1;
          if (next_remaining == '0) begin
            finish_line = 1'b1;
            state_nxt   = IDLE;
          end else begin
            state_nxt = WAIT_SPACE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign go_rejected = go_fill_fifo && ((state != IDLE) || line_done_r);
  assign stay_xfer   = (state == XFER) && (state_nxt == XFER);

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      beat_cnt    <= '0;
      cmplt_seen  <= 1'b0;
      line_done_r <= 1'b0;
      overrun_r   <= 1'b0;
      rd_err_r    <= 1'b0;
    end else begin
      state       <= state_nxt;
      line_done_r <= finish_line | zero_line;
      overrun_r   <= overrun_r | go_rejected;
      rd_err_r    <= rd_err_r | xfer_err;
      beat_cnt    <= stay_xfer ? beat_cnt_nxt : '0;
      cmplt_seen  <= stay_xfer ? (cmplt_seen | mst_cmplt) : 1'b0;
      if (load_line) begin
        cur_addr  <= ddr_addr_to_read;
        remaining <= line_beats;
      end else if (advance) begin
        cur_addr  <= next_addr;
        remaining <= next_remaining;
      end
    end
  end

  always_comb begin
    mst_rd_req     = (state == REQ);
    mst_addr       = (state == REQ) ? cur_addr : '0;
    mst_length     = (state == REQ) ? burst_len : '0;
    mst_rd_dst_rdy = xfer_room;
    busy           = (state != IDLE);
    line_done      = line_done_r;
    overrun        = overrun_r;
    rd_err         = rd_err_r;
  end

endmodule

// File: tb/tb_line_burst_reader.sv
// Directed bench for line_burst_reader: a table of whole-line fetches against
// a behavioural DDR master, then hand sequences for backpressure, errors and reset.
module tb_line_burst_reader;

  localparam int DW = 32;
  localparam int BB = 16;
  localparam int FD = 256;
  localparam int VW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [31:0]   addr_in;
  logic [31:0]   stride_in;
  logic [31:0]   bpp_in;
  logic [VW-1:0] vacancy;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          mst_rd_req;
  logic [31:0]   mst_addr;
  logic [11:0]   mst_length;
  logic          cmdack;
  logic          cmplt;
  logic          merr;
  logic [DW-1:0] rd_data;
  logic          src_rdy;
  logic          dst_rdy;
  logic          busy;
  logic          line_done;
  logic          overrun;
  logic          rd_err;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] next_data;
  logic [31:0] exp_data;

  typedef struct {
    int          nbursts;
    logic [31:0] first_addr;
    logic [31:0] last_addr;
    logic [31:0] first_len;
    logic [31:0] last_len;
    int          pushes;
    int          dones;
    int          data_errs;
    int          req_viol;
    logic        timeout;
  } run_res_t;

  typedef struct {
    logic [31:0] stride;
    logic [31:0] bpp;
    logic [31:0] base;
    int          stall;
    int          cdly;
    int          exp_bursts;
    logic [31:0] exp_first_len;
    logic [31:0] exp_last_len;
    logic [31:0] exp_last_addr;
    int          exp_pushes;
  } vec_t;

  line_burst_reader #(
    .DATA_WIDTH  (DW),
    .BURST_BEATS (BB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .Bus2IP_Clk          (clk),
    .Bus2IP_Reset        (rst),
    .go_fill_fifo        (go),
    .ddr_addr_to_read    (addr_in),
    .LINE_STRIDE         (stride_in),
    .NUM_BYTES_PER_PIXEL (bpp_in),
    .fifo_vacancy        (vacancy),
    .fifo_wr_en          (fifo_wr_en),
    .fifo_wr_data        (fifo_wr_data),
    .mst_rd_req          (mst_rd_req),
    .mst_addr            (mst_addr),
    .mst_length          (mst_length),
    .mst_cmdack          (cmdack),
    .mst_cmplt           (cmplt),
    .mst_error           (merr),
    .mst_rd_data         (rd_data),
    .mst_rd_src_rdy      (src_rdy),
    .mst_rd_dst_rdy      (dst_rdy),
    .busy                (busy),
    .line_done           (line_done),
    .overrun             (overrun),
    .rd_err              (rd_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearMaster();
    cmdack  = 1'b0;
    cmplt   = 1'b0;
    merr    = 1'b0;
    src_rdy = 1'b0;
  endtask

  // Optionally pulses go, then plays the DDR master until the line ends.
  task automatic applyStimulus(
    input  logic        do_go,
    input  logic [31:0] stride,
    input  logic [31:0] bpp,
    input  logic [31:0] base,
    input  int          stall,
    input  int          cdly,
    input  int          err_burst,
    input  int          ovr_cycle,
    input  int          stop_after,
    input  logic        go_on_done,
    output run_res_t    r
  );
    int   phase;
    int   beats_left;
    int   dly;
    logic tog;
    logic fin;
    logic stopped;
    logic hit_err;
    logic busy_s;
    r.nbursts = 0; r.first_addr = 0; r.last_addr = 0; r.first_len = 0; r.last_len = 0;
    r.pushes = 0; r.dones = 0; r.data_errs = 0; r.req_viol = 0; r.timeout = 1'b0;
    phase = 0; beats_left = 0; dly = 0; tog = 1'b1;
    fin = 1'b0; stopped = 1'b0; hit_err = 1'b0;
    if (do_go) begin
      @(negedge clk);
      go = 1'b1; addr_in = base; stride_in = stride; bpp_in = bpp;
    end
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(negedge clk);
      go = (ovr_cycle >= 0) && (cyc == ovr_cycle);
      if (go) addr_in = 32'hDEAD_0000;
      clearMaster();
      busy_s = busy;
      if (line_done) begin
        r.dones++;
        if (go_on_done) go = 1'b1;
      end
      case (phase)
        0: begin
          if (mst_rd_req) begin
            r.nbursts++;
            if (r.nbursts == 1) begin
              r.first_addr = mst_addr;
              r.first_len  = 32'(mst_length);
            end
            r.last_addr = mst_addr;
            r.last_len  = 32'(mst_length);
            cmdack      = 1'b1;
            beats_left  = int'(mst_length >> 2);
            phase       = 1;
          end
        end
        1: begin
          if (mst_rd_req) r.req_viol++;
          src_rdy = (stall != 0) ? tog : 1'b1;
          tog     = ~tog;
          rd_data = next_data;
          if (src_rdy && beats_left == 1 && cdly == 0) begin
            cmplt = 1'b1;
            merr  = (r.nbursts == err_burst);
            if (merr) hit_err = 1'b1;
          end
        end
        default: begin
          if (mst_rd_req) r.req_viol++;
          if (dly == 0) begin
            cmplt = 1'b1;
            merr  = (r.nbursts == err_burst);
            if (merr) hit_err = 1'b1;
            phase = 0;
          end else begin
            dly--;
          end
        end
      endcase
      #1;
      if (fifo_wr_en) begin
        r.pushes++;
        if (fifo_wr_data !== exp_data) r.data_errs++;
        exp_data++;
      end
      if (phase == 1 && src_rdy && dst_rdy) begin
        beats_left--;
        next_data++;
        if (beats_left == 0) begin
          if (cmplt) begin
            phase = 0;
          end else begin
            phase = 2;
            dly   = cdly - 1;
          end
        end
      end
      if (stop_after > 0 && r.pushes >= stop_after) begin
        fin = 1'b1; stopped = 1'b1;
      end else if (!busy_s && (r.dones > 0 || (hit_err && phase == 0))) begin
        fin = 1'b1;
      end
    end
    if (!fin) r.timeout = 1'b1;
    if (!stopped) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        go = 1'b0;
        clearMaster();
        #1;
        if (line_done) r.dones++;
        if (mst_rd_req) r.req_viol++;
        if (fifo_wr_en) r.pushes++;
      end
    end
  endtask

  initial begin
    vec_t     vecs[8];
    run_res_t r;
    int       strays;

    vecs[0] = '{32'd1280, 32'd4, 32'hA800_0000, 0, 0, 80, 32'd64, 32'd64, 32'hA800_13C0, 1280};
    vecs[1] = '{32'd20,   32'd4, 32'h0000_1000, 0, 0, 2,  32'd64, 32'd16, 32'h0000_1040, 20};
    vecs[2] = '{32'd0,    32'd4, 32'h0000_2000, 0, 0, 0,  32'd0,  32'd0,  32'h0000_0000, 0};
    vecs[3] = '{32'd3,    32'd2, 32'h0000_3000, 0, 0, 1,  32'd4,  32'd4,  32'h0000_3000, 1};
    vecs[4] = '{32'd33,   32'd4, 32'h0000_4000, 0, 0, 3,  32'd64, 32'd4,  32'h0000_4080, 33};
    vecs[5] = '{32'd32,   32'd4, 32'hFFFF_FFC0, 0, 0, 2,  32'd64, 32'd64, 32'h0000_0000, 32};
    vecs[6] = '{32'd32,   32'd4, 32'h0000_5000, 1, 3, 2,  32'd64, 32'd64, 32'h0000_5040, 32};
    vecs[7] = '{32'd17,   32'd4, 32'h0000_9000, 0, 1, 2,  32'd64, 32'd4,  32'h0000_9040, 17};

    rst = 1'b1; go = 1'b0; addr_in = '0; stride_in = '0; bpp_in = '0;
    vacancy = VW'(FD); rd_data = '0;
    clearMaster();
    next_data = 32'h1000_0000;
    exp_data  = 32'h1000_0000;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset req", 32'(mst_rd_req), 32'd0);
    checkOutput("reset dst_rdy", 32'(dst_rdy), 32'd0);
    checkOutput("reset line_done", 32'(line_done), 32'd0);
    checkOutput("reset sticky", {30'd0, overrun, rd_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].stride, vecs[i].bpp, vecs[i].base, vecs[i].stall,
                    vecs[i].cdly, 0, -1, 0, 1'b0, r);
      checkOutput($sformatf("v%0d timeout", i), 32'(r.timeout), 32'd0);
      checkOutput($sformatf("v%0d bursts", i), 32'(r.nbursts), 32'(vecs[i].exp_bursts));
      checkOutput($sformatf("v%0d first_addr", i), r.first_addr,
                  (vecs[i].exp_bursts > 0) ? vecs[i].base : 32'd0);
      checkOutput($sformatf("v%0d first_len", i), r.first_len, vecs[i].exp_first_len);
      checkOutput($sformatf("v%0d last_len", i), r.last_len, vecs[i].exp_last_len);
      checkOutput($sformatf("v%0d last_addr", i), r.last_addr, vecs[i].exp_last_addr);
      checkOutput($sformatf("v%0d pushes", i), 32'(r.pushes), 32'(vecs[i].exp_pushes));
      checkOutput($sformatf("v%0d data order", i), 32'(r.data_errs), 32'd0);
      checkOutput($sformatf("v%0d line_done", i), 32'(r.dones), 32'd1);
      checkOutput($sformatf("v%0d early req", i), 32'(r.req_viol), 32'd0);
      checkOutput($sformatf("v%0d busy after", i), 32'(busy), 32'd0);
    end

    // Backpressure: 10 free words cannot take a 16-beat burst.
    vacancy = VW'(10);
    @(negedge clk);
    go = 1'b1; addr_in = 32'h0000_B000; stride_in = 32'd16; bpp_in = 32'd4;
    strays = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      go = 1'b0;
      if (mst_rd_req) strays++;
    end
    checkOutput("bp req held off", 32'(strays), 32'd0);
    checkOutput("bp busy", 32'(busy), 32'd1);
    vacancy = VW'(16);
    @(negedge clk);
    checkOutput("bp req after room", 32'(mst_rd_req), 32'd1);
    checkOutput("bp req addr", mst_addr, 32'h0000_B000);
    applyStimulus(1'b0, 32'd16, 32'd4, 32'h0000_B000, 0, 0, 0, -1, 0, 1'b0, r);
    checkOutput("bp pushes", 32'(r.pushes), 32'd16);
    checkOutput("bp line_done", 32'(r.dones), 32'd1);
    vacancy = VW'(FD);

    // Error on the second burst abandons the line.
    applyStimulus(1'b1, 32'd64, 32'd4, 32'h0000_8000, 0, 0, 2, -1, 0, 1'b0, r);
    checkOutput("err timeout", 32'(r.timeout), 32'd0);
    checkOutput("err bursts", 32'(r.nbursts), 32'd2);
    checkOutput("err pushes", 32'(r.pushes), 32'd32);
    checkOutput("err no line_done", 32'(r.dones), 32'd0);
    checkOutput("err rd_err", 32'(rd_err), 32'd1);
    checkOutput("err busy", 32'(busy), 32'd0);
    checkOutput("err no overrun", 32'(overrun), 32'd0);

    // A second go mid-line is refused and flagged.
    applyStimulus(1'b1, 32'd32, 32'd4, 32'h0000_6000, 0, 0, 0, 3, 0, 1'b0, r);
    checkOutput("ovr overrun", 32'(overrun), 32'd1);
    checkOutput("ovr bursts", 32'(r.nbursts), 32'd2);
    checkOutput("ovr first_addr", r.first_addr, 32'h0000_6000);
    checkOutput("ovr last_addr", r.last_addr, 32'h0000_6040);
    checkOutput("ovr pushes", 32'(r.pushes), 32'd32);
    checkOutput("ovr line_done", 32'(r.dones), 32'd1);

    // Reset after the fifth beat of a burst.
    applyStimulus(1'b1, 32'd16, 32'd4, 32'h0000_7000, 0, 0, 0, -1, 5, 1'b0, r);
    checkOutput("rst pushes before", 32'(r.pushes), 32'd5);
    @(negedge clk);
    rst = 1'b1; go = 1'b0;
    clearMaster();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst req", 32'(mst_rd_req), 32'd0);
    checkOutput("rst addr/len", mst_addr | 32'(mst_length), 32'd0);
    checkOutput("rst dst_rdy", 32'(dst_rdy), 32'd0);
    checkOutput("rst sticky", {30'd0, overrun, rd_err}, 32'd0);
    strays = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      src_rdy = 1'b1; rd_data = 32'hBAD0_0000 + 32'(k); cmplt = (k == 3);
      #1;
      if (fifo_wr_en) strays++;
    end
    checkOutput("rst stray beats", 32'(strays), 32'd0);
    @(negedge clk);
    clearMaster();

    // Fresh line after reset; go during line_done must be refused.
    applyStimulus(1'b1, 32'd20, 32'd4, 32'h0000_C000, 0, 0, 0, -1, 0, 1'b1, r);
    checkOutput("post bursts", 32'(r.nbursts), 32'd2);
    checkOutput("post last_len", r.last_len, 32'd16);
    checkOutput("post pushes", 32'(r.pushes), 32'd20);
    checkOutput("post data order", 32'(r.data_errs), 32'd0);
    checkOutput("post line_done", 32'(r.dones), 32'd1);
    checkOutput("post done-cycle overrun", 32'(overrun), 32'd1);
    checkOutput("post no new req", 32'(r.req_viol), 32'd0);
    checkOutput("post busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
